// File: rtl/clk_freq_meter.sv
// Gated edge counter for checking a test clock against the reference clk.
// meas_clk is synchronized into the clk domain, its rising edges are counted
// over a gate of exactly GATE_CYCLES clk cycles, and the count is reported
// together with a range check against [exp_min, exp_max].
//
// Ports:
//   clk         reference clock (single clock domain)
//   rst         synchronous active-high reset
//   meas_clk    clock under test, asynchronous to clk
//   start       one-cycle measurement request, honoured only when idle
//   exp_min     lowest acceptable edge count, latched on accepted start
//   exp_max     highest acceptable edge count, latched on accepted start
//   busy        high while gating and reporting
//   done        one-cycle pulse; results valid from this cycle
//   edge_count  edges counted in the last gate, held until the next report
//   in_range    exp_min <= edge_count <= exp_max (unsigned)
//   saturated   counter reached full scale and a further edge arrived
module clk_freq_meter #(
  parameter int unsigned GATE_CYCLES = 1000,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             meas_clk,
  input  logic             start,
  input  logic [CNT_W-1:0] exp_min,
  input  logic [CNT_W-1:0] exp_max,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] edge_count,
  output logic             in_range,
  output logic             saturated
);

  localparam int unsigned GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, GATE, REPORT} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   m_s, m_d, rise;
  logic [GW-1:0]          gate_cnt;
  logic                   gate_last;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [CNT_W-1:0]       min_q, max_q;

  // Synchronizer and edge detector run in every state so that a gate opening
  // while meas_clk is already high does not see a spurious rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      m_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], meas_clk};
      m_d    <= m_s;
    end
  end

  assign m_s       = sync_q[SYNC_STAGES-1];
  assign rise      = m_s & ~m_d;
  assign gate_last = (gate_cnt == '0);

  always_comb begin
    cnt_nxt = cnt;
    if (rise && (cnt != '1)) cnt_nxt = cnt + CNT_W'(1);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = GATE;
      GATE:    if (gate_last) state_nxt = REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state != IDLE);
    done = (state == REPORT);
  end

  // Datapath. Results are captured on the final gate cycle (including that
  // cycle's edge) so they are already valid in the REPORT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_cnt   <= '0;
      cnt        <= '0;
      min_q      <= '0;
      max_q      <= '0;
      edge_count <= '0;
      in_range   <= 1'b0;
      saturated  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            gate_cnt  <= GW'(GATE_CYCLES - 1);
            cnt       <= '0;
            saturated <= 1'b0;
            in_range  <= 1'b0;
            min_q     <= exp_min;
            max_q     <= exp_max;
          end
        end
        GATE: begin
          gate_cnt <= gate_cnt - GW'(1);
          cnt      <= cnt_nxt;
          if (rise && (cnt == '1)) saturated <= 1'b1;
          if (gate_last) begin
            edge_count <= cnt_nxt;
            in_range   <= (min_q <= cnt_nxt) && (cnt_nxt <= max_q);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_freq_meter.sv
// Bench for clk_freq_meter: table of measurement vectors checked through an
// expectation queue, plus hand-written sequences for start-while-busy,
// reset mid-gate and counter saturation on a narrow instance.
module tb_clk_freq_meter;

  localparam int unsigned G  = 1000;
  localparam int unsigned GS = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        meas = 1'b0;
  logic        start = 1'b0;
  logic [15:0] exp_min = '0;
  logic [15:0] exp_max = '0;
  logic        busy, done, in_range, saturated;
  logic [15:0] edge_count;

  logic        meas_s = 1'b0;
  logic        start_s = 1'b0;
  logic [3:0]  exp_min_s = '0;
  logic [3:0]  exp_max_s = '0;
  logic        busy_s, done_s, in_range_s, saturated_s;
  logic [3:0]  edge_count_s;

  clk_freq_meter #(.GATE_CYCLES(G), .CNT_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .meas_clk(meas), .start(start),
    .exp_min(exp_min), .exp_max(exp_max), .busy(busy), .done(done),
    .edge_count(edge_count), .in_range(in_range), .saturated(saturated)
  );

  clk_freq_meter #(.GATE_CYCLES(GS), .CNT_W(4), .SYNC_STAGES(2)) dut_s (
    .clk(clk), .rst(rst), .meas_clk(meas_s), .start(start_s),
    .exp_min(exp_min_s), .exp_max(exp_max_s), .busy(busy_s), .done(done_s),
    .edge_count(edge_count_s), .in_range(in_range_s), .saturated(saturated_s)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // meas_clk source: mode 0 = tied low, 1 = tied high, 2 = toggling every
  // 'half' ns. All transitions land at 3 mod 10 ns, clear of clk edges.
  int unsigned mode = 0;
  int unsigned half = 50;
  initial begin
    #3;
    forever begin
      if (mode == 2) begin
        #(half) meas = ~meas;
      end else begin
        meas = (mode == 1);
        #10;
      end
    end
  end

  // Narrow instance: meas_clk period 4 clk.
  initial begin
    #3;
    forever #20 meas_s = ~meas_s;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%0d req=%0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  typedef struct {
    int unsigned done_cyc;
    int unsigned lo;
    int unsigned hi;
    logic        ir;
    logic        sat;
  } exp_t;

  exp_t sbq[$];
  exp_t e_mon;

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done act=1 req=0 (cyc %0d)", cyc);
      end else begin
        e_mon = sbq.pop_front();
        chk("done_cycle", cyc, e_mon.done_cyc);
        total++;
        if (edge_count < e_mon.lo || edge_count > e_mon.hi) begin
          bad++;
          $display("FAIL edge_count act=%0d req=%0d..%0d (cyc %0d)",
                   edge_count, e_mon.lo, e_mon.hi, cyc);
        end
        chk("in_range", in_range, e_mon.ir);
        chk("saturated", saturated, e_mon.sat);
        chk("busy_in_report", busy, 1);
      end
    end
  end

  // Called at a negedge: issue start, queue the expectation.
  task automatic start_meas(input logic [15:0] mn, input logic [15:0] mx,
                            input int unsigned lo, input int unsigned hi,
                            input logic ir);
    exp_t e;
    exp_min = mn;
    exp_max = mx;
    start   = 1'b1;
    e.done_cyc = cyc + G + 1;
    e.lo  = lo;
    e.hi  = hi;
    e.ir  = ir;
    e.sat = 1'b0;
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic drain(input int unsigned limit);
    int unsigned k = 0;
    while (sbq.size() != 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout act=%0d req=0 pending", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
    chk("busy_after_done", busy, 0);
  endtask

  typedef struct {
    int unsigned mode;
    int unsigned half;
    logic [15:0] mn;
    logic [15:0] mx;
    int unsigned lo;
    int unsigned hi;
    logic        ir;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int unsigned n;
    int unsigned k;

    vecs[0] = '{2,  50,  16'd99,  16'd101,   99, 101, 1'b1}; // 10-clk period
    vecs[1] = '{0,  50,  16'd1,   16'd5,      0,   0, 1'b0}; // tied low
    vecs[2] = '{1,  50,  16'd1,   16'd5,      0,   0, 1'b0}; // tied high
    vecs[3] = '{2,  50,  16'd120, 16'd80,    99, 101, 1'b0}; // min > max
    vecs[4] = '{2,  100, 16'd40,  16'd60,    49,  51, 1'b1}; // 20-clk period
    vecs[5] = '{2,  50,  16'd0,   16'd50,    99, 101, 1'b0}; // above max
    vecs[6] = '{0,  50,  16'd0,   16'd0,      0,   0, 1'b1}; // equal bounds
    vecs[7] = '{1,  50,  16'd0,   16'hFFFF,   0,   0, 1'b1}; // full range

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_edge_count", edge_count, 0);
    chk("rst_in_range", in_range, 0);
    chk("rst_saturated", saturated, 0);
    chk("rst_busy_s", busy_s, 0);
    chk("rst_edge_count_s", edge_count_s, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      mode = vecs[i].mode;
      half = vecs[i].half;
      repeat (12) @(negedge clk);
      start_meas(vecs[i].mn, vecs[i].mx, vecs[i].lo, vecs[i].hi, vecs[i].ir);
      drain(G + 50);
    end

    // Starts during busy are ignored; bounds changed mid-gate must not
    // affect the result; a start the cycle after done is accepted.
    mode = 2;
    half = 50;
    repeat (12) @(negedge clk);
    n = cyc;
    start_meas(16'd99, 16'd101, 99, 101, 1'b1);
    while (cyc < n + 5) @(negedge clk);
    start   = 1'b1;
    exp_min = 16'd200;
    exp_max = 16'd300;
    @(negedge clk);
    start = 1'b0;
    while (cyc < n + G) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t4_done_once", done, 1);
    @(negedge clk);
    start_meas(16'd99, 16'd101, 99, 101, 1'b1);
    drain(G + 50);

    // Reset mid-gate: outputs clear, no done pulse afterwards.
    repeat (12) @(negedge clk);
    n = cyc;
    exp_min = 16'd99;
    exp_max = 16'd101;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < n + 500) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_edge_count", edge_count, 0);
    chk("t5_in_range", in_range, 0);
    chk("t5_saturated", saturated, 0);
    repeat (G + 20) @(negedge clk);
    start_meas(16'd99, 16'd101, 99, 101, 1'b1);
    drain(G + 50);

    // Narrow counter saturates: 25 edges into a 4-bit counter.
    repeat (5) @(negedge clk);
    exp_min_s = 4'd0;
    exp_max_s = 4'd15;
    start_s   = 1'b1;
    n = cyc;
    @(negedge clk);
    start_s = 1'b0;
    chk("t3_busy_s", busy_s, 1);
    k = 0;
    while (!done_s && k < GS + 20) begin
      @(negedge clk);
      k++;
    end
    chk("t3_done_s", done_s, 1);
    chk("t3_done_cycle_s", cyc, n + GS + 1);
    chk("t3_edge_count_s", edge_count_s, 15);
    chk("t3_saturated_s", saturated_s, 1);
    chk("t3_in_range_s", in_range_s, 1);
    @(negedge clk);
    chk("t3_busy_after_s", busy_s, 0);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
